// File: rtl/div_if.sv
// ============================================================================
// Module      : div_if
// Description : Operand/result bundle between the execute stage and the divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface div_if;
    logic [31:0] div_data1_i;
    logic [31:0] div_data2_i;
    logic        div_signed_i;
    logic        div_start_i;
    logic        div_cancel_i;
    logic [63:0] div_result_o;
    logic        div_done_o;

    modport master (
        output div_data1_i, div_data2_i, div_signed_i, div_start_i, div_cancel_i,
        input  div_result_o, div_done_o
    );

    modport slave (
        input  div_data1_i, div_data2_i, div_signed_i, div_start_i, div_cancel_i,
        output div_result_o, div_done_o
    );
endinterface

`default_nettype wire

// File: rtl/div.sv
// ============================================================================
// Module      : div
// Description : 32-bit radix-2 restoring divider, signed/unsigned, one quotient
//               bit per cycle. Define DIV_ZERO_FAST_EN to finish divide-by-zero
//               one cycle after start.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module div (
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0]  c_last_cnt = 6'd32;
    localparam logic [31:0] c_all_ones = 32'hFFFF_FFFF;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic [63:0] r_result;
    logic        r_done;

    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quot_nxt;
    logic [5:0]  w_cnt_nxt;
    logic [31:0] w_q_final;
    logic [31:0] w_r_final;

    always_comb begin
        w_dvd_neg  = bus.div_signed_i & bus.div_data1_i[31];
        w_dvs_neg  = bus.div_signed_i & bus.div_data2_i[31];
        w_dvd_mag  = w_dvd_neg ? (32'd0 - bus.div_data1_i) : bus.div_data1_i;
        w_dvs_mag  = w_dvs_neg ? (32'd0 - bus.div_data2_i) : bus.div_data2_i;

        // Remainder stays below the divisor, so the 33-bit borrow is the trial result.
        w_shift    = {r_rem, r_quot[31]};
        w_diff     = w_shift - {1'b0, r_divisor};
        w_qbit     = ~w_diff[32];
        w_rem_nxt  = w_qbit ? w_diff[31:0] : w_shift[31:0];
        w_quot_nxt = {r_quot[30:0], w_qbit};
        w_cnt_nxt  = r_cnt + 6'd1;

        w_q_final  = r_div_zero ? c_all_ones
                   : (r_neg_q ? (32'd0 - w_quot_nxt) : w_quot_nxt);
        w_r_final  = r_div_zero ? r_dividend
                   : (r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 6'd0;
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
            r_quot     <= 32'd0;
            r_rem      <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_result   <= 64'd0;
            r_done     <= 1'b0;
        end else if (bus.div_cancel_i) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.div_start_i) begin
                        r_dividend <= bus.div_data1_i;
                        r_divisor  <= w_dvs_mag;
                        r_quot     <= w_dvd_mag;
                        r_rem      <= 32'd0;
                        r_cnt      <= 6'd0;
                        r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r    <= w_dvd_neg;
                        r_div_zero <= (bus.div_data2_i == 32'd0);
`ifdef DIV_ZERO_FAST_EN
                        if (bus.div_data2_i == 32'd0) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= {bus.div_data1_i, c_all_ones};
                        end else begin
                            r_state <= BUSY;
                        end
`else
                        r_state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (!bus.div_start_i) begin
                        r_state <= IDLE;
                        r_cnt   <= 6'd0;
                    end else begin
                        r_rem  <= w_rem_nxt;
                        r_quot <= w_quot_nxt;
                        r_cnt  <= w_cnt_nxt;
                        if (w_cnt_nxt == c_last_cnt) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= {w_r_final, w_q_final};
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_cnt   <= 6'd0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.div_result_o = r_result;
    assign bus.div_done_o   = r_done;

endmodule

`default_nettype wire
